io_output_formatter: RTL and testbench
======================================

Name: io_output_formatter

Overview:
- Parametrised successor of the I/O unit's output path. It latches a sign+magnitude word on a start pulse and formats it into 5-bit device characters: a sign character, then octal or decimal digits, then a terminator.
- Characters are buffered in an internal FIFO and drained to the output device over a four-phase rdy/ack handshake.
- Sits between op/pnl/pu and the output device. It replaces per-digit AC shifting with internal shifting of a local copy.

Parameters:
- DATA_W, 36, magnitude width in bits; must be a multiple of 12 (octal digits = DATA_W/3, decimal BCD digits = DATA_W/4).
- FIFO_DEPTH, 4, character FIFO entries; power of two, at least 2.
- END_CODE, 5'b00110, terminator character.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start_from_op  in  1  pulse; start formatting the word on data_in/sign_in
- abort_from_pnl  in  1  pulse; abandon the current output
- oct_mode_from_pnl  in  1  level; octal mode
- dec_mode_from_pnl  in  1  level; decimal mode
- stop_after_output_from_pnl  in  1  level; suppress start_pulse_to_pu
- sign_in  in  1  value; sign bit
- data_in  in  DATA_W  value; magnitude (BCD nibbles in decimal mode)
- busy_to_op  out  1  level; high from the start pulse until done
- done_to_op  out  1  pulse; last character acknowledged
- start_pulse_to_pu  out  1  pulse; resume pu after output
- output_rdy_to_dev  out  1  handshake
- output_ack_from_dev  in  1  handshake
- output_data_to_dev  out  5  value; character

Behaviour:
- Reset (resetn=0 at a clk edge): FSMs idle, FIFO empty, every output 0.
- Start: start_from_op in F_IDLE latches sign_in, data_in and mode, and sets busy_to_op the next cycle.
  - Mode is octal if oct_mode_from_pnl=1, else decimal.
  - start_from_op while busy is ignored.
- Formatter FSM F_IDLE -> F_SIGN -> F_NUM -> F_END -> F_DRAIN -> F_IDLE.
  - Each of F_SIGN, F_NUM and F_END pushes one character per cycle, only when the FIFO is not full; otherwise it stalls in place.
  - F_SIGN pushes {4'b1111, sign}.
  - F_NUM emits digits MSB-first from the shift register: octal {2'b10, top 3 bits} with shift left 3; decimal {1'b1, top 4 bits} with shift left 4.
  - A digit counter (NDIG = DATA_W/3 or DATA_W/4) advances per push. The last digit moves the FSM to F_END.
  - F_END pushes END_CODE, then goes to F_DRAIN.
  - F_DRAIN waits until the FIFO is empty and the device FSM is in D_IDLE. It then pulses done_to_op for 1 cycle, plus start_pulse_to_pu in the same cycle if stop_after_output_from_pnl=0. It clears busy and returns to F_IDLE.
- Device FSM D_IDLE/D_RDY/D_ACK:
  - D_IDLE -> D_RDY when the FIFO is non-empty.
  - In D_RDY, rdy=1 and data = FIFO head, held stable.
  - D_RDY -> D_ACK on ack=1; rdy falls next cycle.
  - D_ACK -> D_IDLE on ack=0; the FIFO pops on this transition.
  - output_data_to_dev = 0 whenever rdy=0.
- FIFO:
  - Simultaneous push and pop are both performed; count unchanged.
  - Push when full cannot occur because the formatter stalls. Pop when empty cannot occur.
  - Pointers wrap modulo FIFO_DEPTH.
- Abort: abort_from_pnl at any time clears the FIFO, both FSMs and busy at the next edge.
  - rdy drops immediately; no done or start pulse is issued.
  - Abort takes priority over a simultaneous start.
- Reset mid-operation behaves as abort.
- First character latency: start at edge N -> sign pushed at N+1 -> rdy high at N+2.

Optional Feature:
- IO_LEADING_ZERO_SUPPRESS_EN defined: in F_NUM, zero digits preceding the first non-zero digit are shifted out without a push. At least one digit is always emitted: an all-zero magnitude emits a single zero digit, the last one.
- Undefined: all NDIG digits are emitted.

Test Plan:
- Octal, DATA_W=36, sign=1, data=36'o123, device acks after 2 cycles -> 14 chars: 11111, 9x 10000, 10001, 10010, 10011, 00110; then done_to_op and start_pulse_to_pu.
- Decimal, sign=0, data=36'h000000042, stop_after=1 -> 11110, 7x 10000, 10100, 10010, 00110; done_to_op pulses, start_pulse_to_pu stays 0.
- Slow device (ack 20 cycles after rdy), FIFO_DEPTH=4:
  - formatter stalls with the FIFO at 4 entries;
  - no character is lost or duplicated;
  - output_data_to_dev is stable while rdy=1.
- Abort after 3rd character acked:
  - rdy=0 next cycle, busy=0, no done pulse;
  - a new start then emits a full sequence from the sign character.
- start_from_op during busy -> ignored (sequence unchanged). start and abort in the same cycle -> stays idle.
- With IO_LEADING_ZERO_SUPPRESS_EN, octal data=36'o5 -> 11110, 10101, 00110; data=0 -> 11110, 10000, 00110.

Source files
------------

// File: rtl/io_output_formatter_if.sv
// Output-device port of io_output_formatter: a four-phase rdy/ack handshake
// carrying one 5-bit device character per transfer.
interface io_output_formatter_if;
    logic       output_rdy_to_dev;
    logic       output_ack_from_dev;
    logic [4:0] output_data_to_dev;

    // Formatter side: offers characters and waits for the device to acknowledge.
    modport master (
        output output_rdy_to_dev,
        output output_data_to_dev,
        input  output_ack_from_dev
    );

    // Device side: takes characters and acknowledges them.
    modport slave (
        input  output_rdy_to_dev,
        input  output_data_to_dev,
        output output_ack_from_dev
    );
endinterface

// File: rtl/io_output_formatter.sv
// io_output_formatter: latches a sign+magnitude word on a start pulse. It then
// formats the word into 5-bit device characters: a sign character, then octal
// or BCD digits (MSB first), then a terminator. The characters are buffered in
// a small FIFO. The FIFO is drained to the device over a four-phase rdy/ack
// handshake.
// Optional build macro IO_LEADING_ZERO_SUPPRESS_EN: leading zero digits are
// dropped. The last digit is always emitted.
module io_output_formatter #(
    parameter int         DATA_W     = 36,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [4:0] END_CODE   = 5'b00110
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_from_op,
    input  logic              abort_from_pnl,
    input  logic              oct_mode_from_pnl,
    input  logic              dec_mode_from_pnl,
    input  logic              stop_after_output_from_pnl,
    input  logic              sign_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy_to_op,
    output logic              done_to_op,
    output logic              start_pulse_to_pu,
    io_output_formatter_if.master dev
);

    localparam int NDIG_OCT = DATA_W / 3;
    localparam int NDIG_DEC = DATA_W / 4;
    localparam int DIG_W    = $clog2(NDIG_OCT + 1);
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [DIG_W-1:0] LAST_OCT = DIG_W'(NDIG_OCT - 1);
    localparam logic [DIG_W-1:0] LAST_DEC = DIG_W'(NDIG_DEC - 1);

    typedef enum logic [2:0] {F_IDLE, F_SIGN, F_NUM, F_END, F_DRAIN} f_state_t;
    typedef enum logic [1:0] {D_IDLE, D_RDY, D_ACK} d_state_t;

    f_state_t f_state_reg, f_state_next;
    d_state_t d_state_reg, d_state_next;

    logic              sign_reg;
    logic              oct_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DIG_W-1:0]  dig_cnt_reg;

    logic [4:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [4:0]        data_reg;

    logic       clear;
    logic       mode_oct;
    logic       fifo_full, fifo_empty;
    logic       push_en, pop_en, digit_adv, drain_done, skip_digit;
    logic [4:0] push_data;
    logic [3:0] digit;
    logic       last_digit;

    // Abort is handled exactly like reset: the FIFO, both FSMs and busy are cleared.
    assign clear = !resetn || abort_from_pnl;

    // Octal wins whenever it is selected. Decimal is the fallback, so dec_mode only confirms it.
    assign mode_oct = oct_mode_from_pnl ? 1'b1 : (dec_mode_from_pnl ? 1'b0 : 1'b0);

    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);

    // The current digit is always the top of the local shift copy. An octal
    // digit is zero-extended, so the char becomes {2'b10, d}.
    assign digit      = oct_reg ? {1'b0, shift_reg[DATA_W-1 -: 3]} : shift_reg[DATA_W-1 -: 4];
    assign last_digit = (dig_cnt_reg == (oct_reg ? LAST_OCT : LAST_DEC));

`ifdef IO_LEADING_ZERO_SUPPRESS_EN
    logic lz_reg;   // still inside the run of leading zeros
    assign skip_digit = lz_reg && (digit == 4'd0) && !last_digit;
`else
    assign skip_digit = 1'b0;
`endif

    // Formatter next-state and FIFO push: one character per cycle. Stall while the FIFO is full.
    always_comb begin
        f_state_next = f_state_reg;
        push_en      = 1'b0;
        push_data    = 5'd0;
        digit_adv    = 1'b0;
        drain_done   = 1'b0;
        case (f_state_reg)
            F_IDLE: if (start_from_op) f_state_next = F_SIGN;
            F_SIGN: if (!fifo_full) begin
                push_en      = 1'b1;
                push_data    = {4'b1111, sign_reg};
                f_state_next = F_NUM;
            end
            F_NUM: begin
                if (skip_digit) begin
                    digit_adv = 1'b1;
                end else if (!fifo_full) begin
                    push_en   = 1'b1;
                    push_data = {1'b1, digit};
                    digit_adv = 1'b1;
                    if (last_digit) f_state_next = F_END;
                end
            end
            F_END: if (!fifo_full) begin
                push_en      = 1'b1;
                push_data    = END_CODE;
                f_state_next = F_DRAIN;
            end
            F_DRAIN: if (fifo_empty && d_state_reg == D_IDLE) begin
                drain_done   = 1'b1;
                f_state_next = F_IDLE;
            end
            default: f_state_next = F_IDLE;
        endcase
    end

    // Formatter state register.
    always_ff @(posedge clk) begin
        if (clear) f_state_reg <= F_IDLE;
        else       f_state_reg <= f_state_next;
    end

    // Latch the word on start, then shift it left by one digit per digit consumed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sign_reg    <= 1'b0;
            oct_reg     <= 1'b0;
            shift_reg   <= '0;
            dig_cnt_reg <= '0;
        end else if (f_state_reg == F_IDLE && start_from_op) begin
            sign_reg    <= sign_in;
            oct_reg     <= mode_oct;
            shift_reg   <= data_in;
            dig_cnt_reg <= '0;
        end else if (digit_adv) begin
            shift_reg   <= oct_reg ? (shift_reg << 3) : (shift_reg << 4);
            dig_cnt_reg <= dig_cnt_reg + DIG_W'(1);
        end
    end

`ifdef IO_LEADING_ZERO_SUPPRESS_EN
    // The leading-zero run ends at the first digit that is actually pushed.
    always_ff @(posedge clk) begin
        if (!resetn)                                  lz_reg <= 1'b1;
        else if (f_state_reg == F_IDLE)               lz_reg <= 1'b1;
        else if (f_state_reg == F_NUM && push_en)     lz_reg <= 1'b0;
    end
`endif

    // Device handshake next-state: offer the head, wait for ack, pop when ack is released.
    always_comb begin
        d_state_next = d_state_reg;
        pop_en       = 1'b0;
        case (d_state_reg)
            D_IDLE: if (!fifo_empty) d_state_next = D_RDY;
            D_RDY:  if (dev.output_ack_from_dev) d_state_next = D_ACK;
            D_ACK:  if (!dev.output_ack_from_dev) begin
                d_state_next = D_IDLE;
                pop_en       = 1'b1;
            end
            default: d_state_next = D_IDLE;
        endcase
    end

    // Device state register. The character register holds the head while rdy is up and is zero otherwise.
    always_ff @(posedge clk) begin
        if (clear) begin
            d_state_reg <= D_IDLE;
            data_reg    <= 5'd0;
        end else begin
            d_state_reg <= d_state_next;
            if (d_state_reg == D_IDLE && d_state_next == D_RDY) data_reg <= mem[rd_ptr_reg];
            else if (d_state_next != D_RDY)                    data_reg <= 5'd0;
        end
    end

    // Character storage (no reset: contents are only meaningful below the count).
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_reg] <= push_data;
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign busy_to_op             = (f_state_reg != F_IDLE);
    assign done_to_op             = drain_done && !clear;
    assign start_pulse_to_pu      = drain_done && !clear && !stop_after_output_from_pnl;
    assign dev.output_rdy_to_dev  = (d_state_reg == D_RDY);
    assign dev.output_data_to_dev = data_reg;

endmodule

// File: tb/tb_io_output_formatter.sv
// Self-checking bench for io_output_formatter. A behavioural model derives the
// expected character stream from sign, magnitude and mode. A device responder
// acknowledges characters after a programmable delay.
// Optional build macro IO_LEADING_ZERO_SUPPRESS_EN: the model then drops leading zero digits too.
module tb_io_output_formatter;

    typedef logic [4:0] char_q_t[$];

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_from_op, abort_from_pnl, oct_mode_from_pnl, dec_mode_from_pnl;
    logic        stop_after_output_from_pnl, sign_in;
    logic [35:0] data_in;
    logic        busy_to_op, done_to_op, start_pulse_to_pu;

    io_output_formatter_if dev_if ();

    io_output_formatter #(.DATA_W(36), .FIFO_DEPTH(4), .END_CODE(5'b00110)) dut (
        .clk                        (clk),
        .resetn                     (resetn),
        .start_from_op              (start_from_op),
        .abort_from_pnl             (abort_from_pnl),
        .oct_mode_from_pnl          (oct_mode_from_pnl),
        .dec_mode_from_pnl          (dec_mode_from_pnl),
        .stop_after_output_from_pnl (stop_after_output_from_pnl),
        .sign_in                    (sign_in),
        .data_in                    (data_in),
        .busy_to_op                 (busy_to_op),
        .done_to_op                 (done_to_op),
        .start_pulse_to_pu          (start_pulse_to_pu),
        .dev                        (dev_if)
    );

    always #5 clk = ~clk;

    int      checks_cnt = 0;
    int      errors_cnt = 0;
    int      ack_delay  = 2;
    int      done_cnt   = 0;
    int      spu_cnt    = 0;
    int      max_cnt    = 0;
    bit      dev_on     = 1'b0;
    char_q_t got_q;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: sign char, then every digit of the word in the chosen radix, then the terminator.
    function automatic char_q_t expect_chars(input logic sgn, input logic [35:0] d, input logic oct);
        char_q_t     q;
        int          w, nd, dg;
        bit          seen;
        logic [35:0] t;
        q.push_back(5'(30 + int'(sgn)));
        w    = oct ? 3 : 4;
        nd   = 36 / w;
        seen = 1'b0;
        for (int i = 0; i < nd; i++) begin
            t  = (d >> (w * (nd - 1 - i))) & 36'((1 << w) - 1);
            dg = int'(t);
`ifdef IO_LEADING_ZERO_SUPPRESS_EN
            if (dg == 0 && !seen && i != nd - 1) continue;
`endif
            seen = 1'b1;
            q.push_back(5'(16 + dg));
        end
        q.push_back(5'd6);
        return q;
    endfunction

    // Device responder: it acks after ack_delay cycles. It checks that data is
    // held while rdy is up and is zero while rdy is low.
    initial begin
        logic [4:0] cap;
        bit         lost;
        int         k;
        dev_if.output_ack_from_dev = 1'b0;
        forever begin
            @(negedge clk);
            if (!dev_on) continue;
            if (dev_if.output_rdy_to_dev !== 1'b1) begin
                check_value("data_idle", 64'(dev_if.output_data_to_dev), 64'd0);
                continue;
            end
            cap  = dev_if.output_data_to_dev;
            lost = 1'b0;
            for (int i = 0; i < ack_delay; i++) begin
                @(negedge clk);
                if (dev_if.output_rdy_to_dev !== 1'b1) begin
                    lost = 1'b1;
                    break;
                end
                check_value("data_stable", 64'(dev_if.output_data_to_dev), 64'(cap));
            end
            if (lost) continue;
            dev_if.output_ack_from_dev = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (dev_if.output_rdy_to_dev === 1'b1 && k < 50);
            if (dev_if.output_rdy_to_dev === 1'b1) check_value("rdy_fall", 64'd1, 64'd0);
            dev_if.output_ack_from_dev = 1'b0;
            got_q.push_back(cap);
            $display("char %0d: %b", got_q.size(), cap);
        end
    end

    // Pulse counters. start_pulse_to_pu must always coincide with done_to_op.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (done_to_op === 1'b1) done_cnt++;
            if (start_pulse_to_pu === 1'b1) begin
                spu_cnt++;
                check_value("spu_with_done", 64'(done_to_op), 64'd1);
            end
            if (int'(dut.count_reg) > max_cnt) max_cnt = int'(dut.count_reg);
        end
    end

    task automatic run_seq(input string name, input logic sgn, input logic [35:0] d, input logic oct,
                           input logic stop, input int delay, input bit inject);
        char_q_t exp;
        int      k, n;
        exp = expect_chars(sgn, d, oct);
        got_q.delete();
        done_cnt  = 0;
        spu_cnt   = 0;
        max_cnt   = 0;
        ack_delay = delay;
        @(negedge clk);
        sign_in = sgn; data_in = d; oct_mode_from_pnl = oct; dec_mode_from_pnl = !oct;
        stop_after_output_from_pnl = stop; start_from_op = 1'b1;
        @(negedge clk);
        start_from_op = 1'b0;
        check_value({name, ".busy_n1"}, 64'(busy_to_op), 64'd1);
        check_value({name, ".rdy_n1"}, 64'(dev_if.output_rdy_to_dev), 64'd0);
        @(negedge clk);
        check_value({name, ".rdy_n2"}, 64'(dev_if.output_rdy_to_dev), 64'd0);
        @(negedge clk);
        check_value({name, ".rdy_n3"}, 64'(dev_if.output_rdy_to_dev), 64'd1);
        if (inject) begin
            repeat (3) @(negedge clk);
            start_from_op = 1'b1; sign_in = !sgn; data_in = ~d;
            oct_mode_from_pnl = !oct; dec_mode_from_pnl = oct;
            @(negedge clk);
            start_from_op = 1'b0;
        end
        k = 0;
        while (done_cnt == 0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == 0) check_value({name, ".done_timeout"}, 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        check_value({name, ".busy_end"}, 64'(busy_to_op), 64'd0);
        check_value({name, ".n_chars"}, 64'(got_q.size()), 64'(exp.size()));
        n = (got_q.size() < exp.size()) ? got_q.size() : exp.size();
        for (int i = 0; i < n; i++)
            check_value($sformatf("%s.char%0d", name, i), 64'(got_q[i]), 64'(exp[i]));
        check_value({name, ".done_cnt"}, 64'(done_cnt), 64'd1);
        check_value({name, ".spu_cnt"}, 64'(spu_cnt), stop ? 64'd0 : 64'd1);
        if (delay >= 20) check_value({name, ".fifo_max"}, 64'(max_cnt), 64'd4);
        $display("txn %s: sign=%0b data=%h oct=%0b stop=%0b chars=%0d", name, sgn, d, oct, stop, got_q.size());
    endtask

    function automatic logic [35:0] rand_word(input logic oct);
        logic [35:0] d;
        logic [31:0] lo;
        logic [31:0] hi;
        lo = $urandom();
        hi = $urandom();
        if (oct) d = {hi[3:0], lo};
        else for (int i = 0; i < 9; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
        d = d >> ((oct ? 3 : 4) * $urandom_range(0, oct ? 12 : 9));
        return d;
    endfunction

    initial begin
        int          k;
        logic        oct;
        logic [31:0] r;
        resetn = 1'b0; start_from_op = 1'b0; abort_from_pnl = 1'b0;
        oct_mode_from_pnl = 1'b1; dec_mode_from_pnl = 1'b0;
        stop_after_output_from_pnl = 1'b0; sign_in = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        check_value("rst.busy", 64'(busy_to_op), 64'd0);
        check_value("rst.done", 64'(done_to_op), 64'd0);
        check_value("rst.spu", 64'(start_pulse_to_pu), 64'd0);
        check_value("rst.rdy", 64'(dev_if.output_rdy_to_dev), 64'd0);
        check_value("rst.data", 64'(dev_if.output_data_to_dev), 64'd0);
        resetn = 1'b1;
        dev_on = 1'b1;

        run_seq("oct123", 1'b1, 36'o123, 1'b1, 1'b0, 2, 1'b0);
        run_seq("dec42", 1'b0, 36'h000000042, 1'b0, 1'b1, 2, 1'b0);
        run_seq("slow", 1'b1, 36'o765432101234, 1'b1, 1'b0, 20, 1'b0);
        run_seq("oct5", 1'b0, 36'o5, 1'b1, 1'b0, 1, 1'b0);
        run_seq("zero", 1'b0, 36'o0, 1'b1, 1'b0, 0, 1'b0);
        run_seq("inject", 1'b1, 36'h123456789, 1'b0, 1'b0, 3, 1'b1);

        // Abort after the third character has been acknowledged.
        got_q.delete(); done_cnt = 0; spu_cnt = 0; ack_delay = 2;
        @(negedge clk);
        sign_in = 1'b1; data_in = 36'o777; oct_mode_from_pnl = 1'b1; dec_mode_from_pnl = 1'b0;
        stop_after_output_from_pnl = 1'b0; start_from_op = 1'b1;
        @(negedge clk);
        start_from_op = 1'b0;
        k = 0;
        while (got_q.size() < 3 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_value("abort.third_acked", 64'(got_q.size() >= 3), 64'd1);
        abort_from_pnl = 1'b1;
        @(negedge clk);
        abort_from_pnl = 1'b0;
        check_value("abort.rdy", 64'(dev_if.output_rdy_to_dev), 64'd0);
        check_value("abort.busy", 64'(busy_to_op), 64'd0);
        repeat (10) @(negedge clk);
        check_value("abort.no_done", 64'(done_cnt), 64'd0);
        check_value("abort.no_spu", 64'(spu_cnt), 64'd0);
        check_value("abort.rdy_late", 64'(dev_if.output_rdy_to_dev), 64'd0);
        $display("txn abort: chars before abort=%0d", got_q.size());
        run_seq("after_abort", 1'b0, 36'o1234, 1'b1, 1'b0, 1, 1'b0);

        // A start together with an abort must leave the block idle.
        done_cnt = 0;
        @(negedge clk);
        start_from_op = 1'b1; abort_from_pnl = 1'b1;
        @(negedge clk);
        start_from_op = 1'b0; abort_from_pnl = 1'b0;
        check_value("start_abort.busy", 64'(busy_to_op), 64'd0);
        repeat (5) @(negedge clk);
        check_value("start_abort.rdy", 64'(dev_if.output_rdy_to_dev), 64'd0);
        check_value("start_abort.done", 64'(done_cnt), 64'd0);
        $display("txn start_abort: idle=%0b", !busy_to_op);

        for (int i = 0; i < 8; i++) begin
            r   = $urandom();
            oct = r[0];
            run_seq($sformatf("rand%0d", i), r[1], rand_word(oct), oct, r[2], int'(r[6:4]) % 6, r[7]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
